// File: rtl/bram_stream_pkg.sv
// bram_stream_pkg: shared FSM state type and circular address increment
package bram_stream_pkg;
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;
  function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned l);
    return (addr >= l - 1) ? 0 : addr + 1;
  endfunction
endpackage

// File: rtl/stream_fifo2.sv
// stream_fifo2: 2-entry FIFO with simultaneous push/pop and occupancy count
module stream_fifo2 #(
  parameter int DW = 33
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [1:0]    count
);
  logic [DW-1:0] mem [2];
  logic wr_ptr, rd_ptr;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      count  <= count + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: rtl/bram_frame_reader.sv
// bram_frame_reader: streams a frame of words from a block RAM read port onto a valid/ready stream
module bram_frame_reader
  import bram_stream_pkg::*;
#(
  parameter  int W      = 32,
  parameter  int L      = 375,
  localparam int ADDR_W = $clog2(L)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   start_len,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [W-1:0]      rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [W-1:0]      m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);
  state_t state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0] remaining;
  logic inflight, inflight_last, start_hs, pop, issue, final_issue;
  logic [1:0] count;
  assign start_ready = rst_n && state == S_IDLE;
  assign busy        = state != S_IDLE;
  assign start_hs    = start_valid && start_ready;
  assign rd_addr     = ptr;
  assign m_valid     = count != 2'd0;
  assign pop         = m_valid && m_ready;
  // Credit check counts the word still in the RAM pipeline so the FIFO never overflows
  assign issue       = state == S_STREAM && remaining != '0 &&
                       ({1'b0, count} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
  assign final_issue = issue && remaining == 'd1;
  stream_fifo2 #(.DW(W + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .din   ({inflight_last, rd_data}),
    .pop   (pop),
    .dout  ({m_last, m_data}),
    .count (count)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == S_IDLE   ? ((start_hs && start_len != '0) ? S_STREAM : S_IDLE) :
                state == S_STREAM ? (final_issue ? S_DRAIN : S_STREAM) :
                (pop && m_last)   ? S_IDLE : S_DRAIN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr           <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      if (start_hs) begin
        ptr       <= start_addr;
        remaining <= start_len;
      end else if (issue) begin
        ptr       <= ADDR_W'(wrap_inc(32'(ptr), L));
        remaining <= remaining - 1'b1;
      end
      inflight      <= issue;
      inflight_last <= final_issue;
      done          <= (start_hs && start_len == '0) || (state == S_DRAIN && pop && m_last);
    end
endmodule

// File: tb/tb_bram_frame_reader.sv
// tb_bram_frame_reader: scoreboard bench with a behavioural RAM holding RAM[i]=i+0x100
module tb_bram_frame_reader;
  localparam int W = 32, L = 375, AW = $clog2(L);
  logic clk = 0, rst_n = 0, start_valid = 0, m_ready = 1, rnd = 0;
  logic start_ready, m_valid, m_last, busy, done;
  logic [AW-1:0] start_addr = '0, rd_addr;
  logic [AW:0] start_len = '0;
  logic [W-1:0] rd_data = '0, m_data;
  logic [W:0] q [$];
  logic [W:0] stall_word, exp_word;
  logic stall = 0;
  int cyc = 0, pass_n = 0, total_n = 0, frame_words = 0, first_cyc = 0, last_cyc = 0;
  int start_cyc = 0, done_due = -1, n_starts = 0, base;

  bram_frame_reader #(.W(W), .L(L)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .start_addr(start_addr), .start_len(start_len), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_data <= 32'h100 + 32'(rd_addr);
  end
  always @(posedge clk) begin
    #1;
    m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  always @(posedge clk)
    if (rst_n && start_valid && start_ready)
      assert (start_addr < L && start_len <= L) else $error("illegal start command");

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (ok) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk)
    if (!rst_n) stall = 0;
    else begin
      if (stall)
        chk(m_valid && {m_last, m_data} == stall_word, "hold", {m_valid, m_last, m_data}, {1'b1, stall_word});
      if (done || cyc == done_due)
        chk(done && cyc == done_due, "done_timing", 64'(cyc), 64'(done_due));
      if (start_valid && start_ready) begin
        n_starts++;
        start_cyc = cyc;
        if (start_len == '0) done_due = cyc + 1;
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) chk(0, "unexpected_word", {m_last, m_data}, 0);
        else begin
          exp_word = q.pop_front();
          chk({m_last, m_data} == exp_word, "word", {m_last, m_data}, exp_word);
        end
        if (frame_words == 0) first_cyc = cyc;
        frame_words++;
        if (m_last) begin
          last_cyc = cyc;
          done_due = cyc + 1;
        end
      end
      stall = m_valid && !m_ready;
      stall_word = {m_last, m_data};
    end

  task automatic expect_frame(input int a, input int n);
    for (int i = 0; i < n; i++) q.push_back({i == n - 1, 32'h100 + 32'((a + i) % L)});
  endtask

  task automatic send(input int a, input int n);
    for (int i = 0; i < 100 && !start_ready; i++) begin
      @(posedge clk);
      #1;
    end
    chk(start_ready, "start_ready_wait", 64'(start_ready), 1);
    expect_frame(a, n);
    frame_words = 0;
    start_addr = AW'(a);
    start_len = (AW + 1)'(n);
    start_valid = 1;
    @(posedge clk);
    #1 start_valid = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (!busy && q.size() == 0) break;
    end
    chk(!busy && q.size() == 0, "idle_timeout", 64'(q.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk(!m_valid, "rst_m_valid", 64'(m_valid), 0);
    chk(!m_last, "rst_m_last", 64'(m_last), 0);
    chk(!done, "rst_done", 64'(done), 0);
    chk(!busy, "rst_busy", 64'(busy), 0);
    chk(!start_ready, "rst_start_ready", 64'(start_ready), 0);
    chk(rd_addr == '0, "rst_rd_addr", 64'(rd_addr), 0);
    rst_n = 1;
    @(negedge clk);
    chk(start_ready, "start_ready_after_rst", 64'(start_ready), 1);

    send(5, 4);
    wait_idle();
    chk(frame_words == 4, "t1_count", 64'(frame_words), 4);
    chk(first_cyc - start_cyc == 3, "t1_latency", 64'(first_cyc - start_cyc), 3);
    chk(last_cyc - first_cyc == 3, "t1_throughput", 64'(last_cyc - first_cyc), 3);

    send(373, 4);
    wait_idle();
    chk(frame_words == 4, "t2_count", 64'(frame_words), 4);
    chk(last_cyc - first_cyc == 3, "t2_throughput", 64'(last_cyc - first_cyc), 3);

    rnd = 1;
    send(20, 8);
    wait_idle();
    rnd = 0;
    chk(frame_words == 8, "t3_count", 64'(frame_words), 8);

    send(7, 0);
    wait_idle();
    chk(frame_words == 0, "t4_no_words", 64'(frame_words), 0);
    chk(start_ready, "t4_ready", 64'(start_ready), 1);

    base = n_starts;
    expect_frame(10, 3);
    expect_frame(10, 3);
    frame_words = 0;
    start_addr = AW'(10);
    start_len = (AW + 1)'(3);
    start_valid = 1;
    for (int i = 0; i < 100 && n_starts - base < 2; i++) begin
      @(posedge clk);
      #1;
    end
    start_valid = 0;
    wait_idle();
    chk(n_starts - base == 2, "t5_starts", 64'(n_starts - base), 2);
    chk(frame_words == 6, "t5_count", 64'(frame_words), 6);

    send(100, 10);
    for (int i = 0; i < 100 && frame_words < 3; i++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 0;
    #1;
    chk(!m_valid, "t6_abort_valid", 64'(m_valid), 0);
    chk(!busy, "t6_abort_busy", 64'(busy), 0);
    q.delete();
    done_due = -1;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk(!done, "t6_no_done", 64'(done), 0);
    send(200, 2);
    wait_idle();
    chk(frame_words == 2, "t6_count", 64'(frame_words), 2);

    chk(q.size() == 0, "queue_empty", 64'(q.size()), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
